// File: rtl/trigger_seq_pkg.sv
// ============================================================================
// trigger_seq_pkg : shared constants and stage config type for trigger_seq
// Rev 1.0
// ============================================================================
`default_nettype none

package trigger_seq_pkg;

  localparam logic [1:0] STATE_TRIG_STANDBY = 2'd0;
  localparam logic [1:0] STATE_TRIG_ARMED   = 2'd1;
  localparam logic [1:0] STATE_TRIG_DELAY   = 2'd2;
  localparam logic [1:0] STATE_TRIG_FIRED   = 2'd3;

  localparam logic [7:0] CMD_TRIG_RUN            = 8'd0;
  localparam logic [7:0] CMD_TRIG_HALT           = 8'd1;
  localparam logic [7:0] CMD_TRIG_SET_VALUE      = 8'd2;
  localparam logic [7:0] CMD_TRIG_SET_VMASK      = 8'd3;
  localparam logic [7:0] CMD_TRIG_SET_EVALUE     = 8'd4;
  localparam logic [7:0] CMD_TRIG_SET_EMASK      = 8'd5;
  localparam logic [7:0] CMD_TRIG_SET_RANGE      = 8'd6;
  localparam logic [7:0] CMD_TRIG_SET_CONFIG     = 8'd7;
  localparam logic [7:0] CMD_TRIG_SET_SERIALOPTS = 8'd8;

  localparam int CFG_COUNT_LSB  = 0;
  localparam int CFG_COUNT_MSB  = 15;
  localparam int CFG_CONTIG_BIT = 16;
  localparam int CFG_FINAL_BIT  = 17;

  typedef enum logic [1:0] {
    ST_STANDBY = STATE_TRIG_STANDBY,
    ST_ARMED   = STATE_TRIG_ARMED,
    ST_DELAY   = STATE_TRIG_DELAY,
    ST_FIRED   = STATE_TRIG_FIRED
  } trig_state_e;

  // Data fields are held at the maximum width; bits above DATA_WIDTH stay zero.
  typedef struct packed {
    logic [31:0] value;
    logic [31:0] vmask;
    logic [31:0] evalue;
    logic [31:0] emask;
    logic [15:0] count;
    logic        contiguous;
    logic        final_stg;
  } stage_cfg_t;

  function automatic logic [15:0] eff_count(input logic [15:0] cnt);
    return (cnt == 16'd0) ? 16'd1 : cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trigger_seq_if.sv
// ============================================================================
// trigger_seq_if : command bus between host controller and trigger_seq
// Rev 1.0
// ============================================================================
`default_nettype none

interface trigger_seq_if #(
  parameter int NUM_STAGES = 4
);
  logic [7:0]            command;
  logic                  cmd_valid;
  logic [31:0]           config_in;
  logic [NUM_STAGES-1:0] stage_we;

  modport master (output command, cmd_valid, config_in, stage_we);
  modport slave  (input  command, cmd_valid, config_in, stage_we);
endinterface

`default_nettype wire

// File: rtl/trigger_seq_stage_cond.sv
// ============================================================================
// trigger_stage_cond : combinational level/edge hit for one trigger stage
// Rev 1.0
// ============================================================================
`default_nettype none

module trigger_stage_cond
  import trigger_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  stage_cfg_t            cfg_i,
  input  logic [DATA_WIDTH-1:0] cur_i,
  input  logic [DATA_WIDTH-1:0] prev_i,
  input  logic                  prev_valid_i,
  output logic                  hit_o
);
  logic [31:0] w_cur;
  logic [31:0] w_prev;
  logic        w_level_ok;
  logic        w_edge_ok;

  assign w_cur  = 32'(cur_i);
  assign w_prev = 32'(prev_i);

  assign w_level_ok = (((w_cur ^ cfg_i.value) & cfg_i.vmask) == 32'd0);
  // Every edge-masked bit must have toggled and landed on its evalue bit.
  assign w_edge_ok  = (cfg_i.emask == 32'd0) ||
                      (prev_valid_i &&
                       (((w_cur ^ w_prev) & cfg_i.emask) == cfg_i.emask) &&
                       (((w_cur ^ cfg_i.evalue) & cfg_i.emask) == 32'd0));

  assign hit_o = w_level_ok && w_edge_ok;
endmodule

`default_nettype wire

// File: rtl/trigger_seq.sv
// ============================================================================
// trigger_seq : multi-stage trigger sequencer with post-trigger delay
// Rev 1.0
// ============================================================================
`default_nettype none

module trigger_seq
  import trigger_seq_pkg::*;
#(
  parameter  int NUM_STAGES = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int CNT_WIDTH  = 16,
  parameter  int DLY_WIDTH  = 24,
  localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  inclk,
  input  logic                  rst_n,
  trigger_seq_if.slave          cmd_if,
  input  logic [DATA_WIDTH-1:0] inport,
  output logic                  triggered,
  output logic [1:0]            trig_state,
  output logic [IDX_W-1:0]      stage_idx
);
  localparam logic [IDX_W-1:0]     IDX_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [DLY_WIDTH-1:0] DLY_ONE = 1;

  stage_cfg_t            cfg_q [NUM_STAGES];
  logic [DLY_WIDTH-1:0]  delay_q;
  logic [DATA_WIDTH-1:0] cur_q, prev_q;
  logic                  cur_valid_q, prev_valid_q;
  trig_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  occ_q, occ_d;
  logic [DLY_WIDTH-1:0]  dly_q, dly_d;

  logic                  w_cmd_run, w_cmd_halt;
  logic [31:0]           w_data_ext;
  logic                  w_unused_cfg;
  logic [NUM_STAGES-1:0] w_hit_vec;
  logic                  w_hit;
  logic [15:0]           w_sel_count;
  logic                  w_sel_contig, w_sel_final;
  logic [CNT_WIDTH-1:0]  w_occ_inc;
  logic                  w_count_done, w_last_stage;

  assign w_cmd_run    = cmd_if.cmd_valid && (cmd_if.command == CMD_TRIG_RUN);
  assign w_cmd_halt   = cmd_if.cmd_valid && (cmd_if.command == CMD_TRIG_HALT);
  assign w_data_ext   = 32'(cmd_if.config_in[DATA_WIDTH-1:0]);
  assign w_unused_cfg = ^cmd_if.config_in;

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGES; i++) cfg_q[i] <= '0;
      delay_q <= '0;
    end else if (cmd_if.cmd_valid && (state_q == ST_STANDBY)) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (cmd_if.stage_we[i]) begin
          case (cmd_if.command)
            CMD_TRIG_SET_VALUE:  cfg_q[i].value  <= w_data_ext;
            CMD_TRIG_SET_VMASK:  cfg_q[i].vmask  <= w_data_ext;
            CMD_TRIG_SET_EVALUE: cfg_q[i].evalue <= w_data_ext;
            CMD_TRIG_SET_EMASK:  cfg_q[i].emask  <= w_data_ext;
            CMD_TRIG_SET_CONFIG: begin
              cfg_q[i].count      <= cmd_if.config_in[CFG_COUNT_MSB:CFG_COUNT_LSB];
              cfg_q[i].contiguous <= cmd_if.config_in[CFG_CONTIG_BIT];
              cfg_q[i].final_stg  <= cmd_if.config_in[CFG_FINAL_BIT];
            end
            default: ;
          endcase
        end
      end
      if (cmd_if.command == CMD_TRIG_SET_RANGE) delay_q <= cmd_if.config_in[DLY_WIDTH-1:0];
    end
  end

  // A sample taken on the RUN edge predates the run and is never evaluated.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q        <= '0;
      prev_q       <= '0;
      cur_valid_q  <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      cur_q  <= inport;
      prev_q <= cur_q;
      if (w_cmd_run) begin
        cur_valid_q  <= 1'b0;
        prev_valid_q <= 1'b0;
      end else begin
        cur_valid_q  <= 1'b1;
        prev_valid_q <= cur_valid_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    trigger_stage_cond #(.DATA_WIDTH(DATA_WIDTH)) u_cond (
      .cfg_i        (cfg_q[g]),
      .cur_i        (cur_q),
      .prev_i       (prev_q),
      .prev_valid_i (prev_valid_q),
      .hit_o        (w_hit_vec[g])
    );
  end

  assign w_hit        = w_hit_vec[idx_q];
  assign w_sel_count  = cfg_q[idx_q].count;
  assign w_sel_contig = cfg_q[idx_q].contiguous;
  assign w_sel_final  = cfg_q[idx_q].final_stg;
  assign w_occ_inc    = (&occ_q) ? occ_q : (occ_q + CNT_ONE);
  assign w_count_done = (32'(w_occ_inc) >= 32'(eff_count(w_sel_count)));
  assign w_last_stage = (32'(idx_q) == 32'(NUM_STAGES - 1));

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STANDBY;
      idx_q   <= '0;
      occ_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      occ_q   <= occ_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    occ_d   = occ_q;
    dly_d   = dly_q;
    if (w_cmd_run) begin
      state_d = ST_ARMED;
      idx_d   = '0;
      occ_d   = '0;
    end else if (w_cmd_halt) begin
      state_d = ST_STANDBY;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (cur_valid_q) begin
            if (w_hit) begin
              if (w_count_done) begin
                if (w_sel_final || w_last_stage) begin
                  if (delay_q != '0) begin
                    state_d = ST_DELAY;
                    dly_d   = delay_q;
                  end else begin
                    state_d = ST_FIRED;
                  end
                end else begin
                  idx_d = idx_q + IDX_ONE;
                  occ_d = '0;
                end
              end else begin
                occ_d = w_occ_inc;
              end
            end else if (w_sel_contig) begin
              occ_d = '0;
            end
          end
        end
        // Loaded with D on entry; fires on the D-th edge spent here.
        ST_DELAY: begin
          if (dly_q <= DLY_ONE) state_d = ST_FIRED;
          else                  dly_d   = dly_q - DLY_ONE;
        end
        default: ;
      endcase
    end
  end

  assign triggered  = (state_q == ST_FIRED);
  assign trig_state = state_q;
  assign stage_idx  = idx_q;
endmodule

`default_nettype wire

// File: tb/tb_trigger_seq.sv
// ============================================================================
// tb_trigger_seq : directed tables plus randomized model check for trigger_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_trigger_seq;
  import trigger_seq_pkg::*;

  localparam int NS  = 4;
  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int DLW = 24;
  localparam int IW  = 2;
  localparam int N   = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] inport;
  logic          triggered;
  logic [1:0]    trig_state;
  logic [IW-1:0] stage_idx;

  always #5 clk = ~clk;

  trigger_seq_if #(.NUM_STAGES(NS)) cif ();

  trigger_seq #(.NUM_STAGES(NS), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .DLY_WIDTH(DLW)) dut (
    .inclk      (clk),
    .rst_n      (rst_n),
    .cmd_if     (cif),
    .inport     (inport),
    .triggered  (triggered),
    .trig_state (trig_state),
    .stage_idx  (stage_idx)
  );

  typedef struct {
    logic [DW-1:0] din;
    logic          trig;
    logic [1:0]    st;
    logic [IW-1:0] idx;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Randomized-run reference data
  int rv[NS], rvm[NS], rev[NS], rem[NS], rcnt[NS], rcon[NS], rfin[NS];
  int rdly;
  int smp[N];
  int exp_st[N+2], exp_ix[N+2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_outs(input string name, input logic tr, input logic [1:0] st, input logic [IW-1:0] ix);
    chk({name, ".triggered"}, 32'(triggered), 32'(tr));
    chk({name, ".trig_state"}, 32'(trig_state), 32'(st));
    chk({name, ".stage_idx"}, 32'(stage_idx), 32'(ix));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [7:0] c, input logic [31:0] d, input logic [NS-1:0] we);
    cif.command   = c;
    cif.config_in = d;
    cif.stage_we  = we;
    cif.cmd_valid = 1'b1;
    tick();
    cif.cmd_valid = 1'b0;
    cif.stage_we  = '0;
  endtask

  task automatic cfg_stage(input int s, input int val, input int vm, input int ev, input int em,
                           input int cnt, input bit con, input bit fin);
    logic [NS-1:0] we;
    we = NS'(1) << s;
    cmd(CMD_TRIG_SET_VALUE,  32'(val), we);
    cmd(CMD_TRIG_SET_VMASK,  32'(vm),  we);
    cmd(CMD_TRIG_SET_EVALUE, 32'(ev),  we);
    cmd(CMD_TRIG_SET_EMASK,  32'(em),  we);
    cmd(CMD_TRIG_SET_CONFIG, {14'd0, fin, con, 16'(cnt)}, we);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #3;
    chk_outs({name, ".reset"}, 1'b0, STATE_TRIG_STANDBY, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic add(input logic [DW-1:0] d, input logic tr, input logic [1:0] st, input logic [IW-1:0] ix);
    vec_t v;
    v.din = d; v.trig = tr; v.st = st; v.idx = ix;
    tbl.push_back(v);
  endtask

  task automatic run_tbl(input string name);
    foreach (tbl[i]) begin
      inport = tbl[i].din;
      tick();
      chk_outs($sformatf("%s[%0d]", name, i), tbl[i].trig, tbl[i].st, tbl[i].idx);
    end
    tbl.delete();
  endtask

  function automatic bit mhit(int s, int j);
    int  cur, prv;
    bit  lvl, edg;
    cur = smp[j];
    prv = (j > 0) ? smp[j-1] : 0;
    lvl = (((cur ^ rv[s]) & rvm[s]) == 0);
    edg = (rem[s] == 0) ||
          ((j > 0) && (((cur ^ prv) & rem[s]) == rem[s]) && (((cur ^ rev[s]) & rem[s]) == 0));
    return lvl && edg;
  endfunction

  // Expected status after each edge c following RUN; sample j is judged at edge j+2
  // and the delay is tracked as an absolute firing time.
  task automatic build_model();
    int mst, midx, mcnt, fire_at, tgt;
    mst = 1; midx = 0; mcnt = 0; fire_at = 0;
    for (int c = 1; c <= N + 1; c++) begin
      if (mst == 1 && c >= 2) begin
        if (mhit(midx, c - 2)) begin
          mcnt++;
          tgt = (rcnt[midx] == 0) ? 1 : rcnt[midx];
          if (mcnt >= tgt) begin
            if (rfin[midx] != 0 || midx == NS - 1) begin
              fire_at = c + rdly;
              mst = (rdly == 0) ? 3 : 2;
            end else begin
              midx++;
              mcnt = 0;
            end
          end
        end else if (rcon[midx] != 0) begin
          mcnt = 0;
        end
      end else if (mst == 2 && c >= fire_at) begin
        mst = 3;
      end
      exp_st[c] = mst;
      exp_ix[c] = midx;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    inport = '0;
    cif.command = '0; cif.config_in = '0; cif.stage_we = '0; cif.cmd_valid = 1'b0;
    #2;

    // Single level stage, delay 0
    do_reset("t1");
    cfg_stage(0, 1, 1, 0, 0, 1, 0, 1);
    inport = '0;
    cmd(CMD_TRIG_RUN, 0, '0);
    add(0, 0, 1, 0); add(1, 0, 1, 0); add(1, 1, 3, 0); add(0, 1, 3, 0);
    run_tbl("t1");

    // Rising edge on bit0 then level on bit1
    do_reset("t2");
    cfg_stage(0, 0, 0, 1, 1, 1, 0, 0);
    cfg_stage(1, 2, 2, 0, 0, 1, 0, 1);
    inport = '0;
    cmd(CMD_TRIG_RUN, 0, '0);
    add(1, 0, 1, 0); add(0, 0, 1, 0); add(1, 0, 1, 0); add(2, 0, 1, 1); add(2, 1, 3, 1);
    run_tbl("t2");
    cmd(CMD_TRIG_RUN, 0, '0);
    chk_outs("t2.rerun", 1'b0, STATE_TRIG_ARMED, '0);

    // Count 3, non-contiguous
    do_reset("t3a");
    cfg_stage(0, 1, 1, 0, 0, 3, 0, 1);
    inport = '0;
    cmd(CMD_TRIG_RUN, 0, '0);
    add(1, 0, 1, 0); add(0, 0, 1, 0); add(1, 0, 1, 0); add(1, 0, 1, 0); add(0, 1, 3, 0);
    run_tbl("t3a");

    // Count 3, contiguous: the 0 breaks the run
    do_reset("t3b");
    cfg_stage(0, 1, 1, 0, 0, 3, 1, 1);
    inport = '0;
    cmd(CMD_TRIG_RUN, 0, '0);
    add(1, 0, 1, 0); add(1, 0, 1, 0); add(0, 0, 1, 0); add(1, 0, 1, 0);
    add(1, 0, 1, 0); add(1, 0, 1, 0); add(0, 1, 3, 0);
    run_tbl("t3b");

    // Delay 5, then HALT during DELAY
    do_reset("t4");
    cfg_stage(0, 1, 1, 0, 0, 1, 0, 1);
    cmd(CMD_TRIG_SET_RANGE, 5, '0);
    inport = '0;
    cmd(CMD_TRIG_RUN, 0, '0);
    add(0, 0, 1, 0); add(1, 0, 1, 0);
    for (int k = 0; k < 5; k++) add(1, 0, 2, 0);
    add(1, 1, 3, 0);
    run_tbl("t4");
    inport = '0;
    cmd(CMD_TRIG_RUN, 0, '0);
    add(0, 0, 1, 0); add(1, 0, 1, 0); add(1, 0, 2, 0); add(1, 0, 2, 0);
    run_tbl("t4h");
    cmd(CMD_TRIG_HALT, 0, '0);
    chk_outs("t4.halt", 1'b0, STATE_TRIG_STANDBY, '0);

    // Asynchronous reset while FIRED, then config must be all-zero
    inport = '0;
    cmd(CMD_TRIG_RUN, 0, '0);
    add(0, 0, 1, 0); add(1, 0, 1, 0);
    for (int k = 0; k < 5; k++) add(1, 0, 2, 0);
    add(1, 1, 3, 0);
    run_tbl("t6pre");
    rst_n = 1'b0;
    #2;
    chk_outs("t6.async", 1'b0, STATE_TRIG_STANDBY, '0);
    @(negedge clk);
    rst_n = 1'b1;
    inport = '0;
    cmd(CMD_TRIG_RUN, 0, '0);
    add(0, 0, 1, 0); add(0, 0, 1, 1); add(0, 0, 1, 2); add(0, 0, 1, 3); add(0, 1, 3, 3);
    run_tbl("t6zero");

    // SET_VALUE while ARMED must not take effect
    do_reset("t5");
    cfg_stage(0, 1, 1, 0, 0, 1, 0, 1);
    inport = '0;
    cmd(CMD_TRIG_RUN, 0, '0);
    cmd(CMD_TRIG_SET_VALUE, 0, 4'b0001);
    chk_outs("t5.cmd", 1'b0, STATE_TRIG_ARMED, '0);
    add(0, 0, 1, 0); add(1, 0, 1, 0); add(1, 1, 3, 0);
    run_tbl("t5");

    // Randomized configurations against the reference model
    for (int t = 0; t < 20; t++) begin
      cmd(CMD_TRIG_HALT, 0, '0);
      for (int s = 0; s < NS; s++) begin
        rv[s]   = int'($urandom_range(0, 7));
        rvm[s]  = int'($urandom_range(0, 7));
        rev[s]  = int'($urandom_range(0, 7));
        rem[s]  = ($urandom_range(0, 1) == 1) ? (1 << $urandom_range(0, 2)) : 0;
        rcnt[s] = int'($urandom_range(0, 3));
        rcon[s] = int'($urandom_range(0, 1));
        rfin[s] = ($urandom_range(0, 3) == 0) ? 1 : 0;
        cfg_stage(s, rv[s], rvm[s], rev[s], rem[s], rcnt[s], rcon[s][0], rfin[s][0]);
      end
      rdly = int'($urandom_range(0, 3));
      cmd(CMD_TRIG_SET_RANGE, 32'(rdly), '0);
      for (int j = 0; j < N; j++) smp[j] = int'($urandom_range(0, 7));
      build_model();
      inport = '0;
      cmd(CMD_TRIG_RUN, 0, '0);
      for (int c = 1; c <= N + 1; c++) begin
        inport = (c - 1 < N) ? DW'(smp[c-1]) : '0;
        tick();
        chk_outs($sformatf("rnd%0d.e%0d", t, c), (exp_st[c] == 3), 2'(exp_st[c]), IW'(exp_ix[c]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
